// File: rtl/instr_cache.sv
// +----------------------------------------------------------------------------+
// | instr_cache : direct-mapped read-only instruction cache, 32-byte lines      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_cache #(
   parameter int NUM_LINES = 64,
   parameter int INDEX_W   = $clog2(NUM_LINES),
   parameter int TAG_W     = 32 - 5 - INDEX_W
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [31:0]  Instr_address_2IC,
   output logic [31:0]  Instr1_fIC,
   output logic [31:0]  Instr2_fIC,
   output logic         Instr2_valid,
   output logic         Instr_valid,
   input  logic         flush,
   output logic [31:0]  Instr_address_2IM,
   output logic         iBlkRead,
   input  logic [255:0] block_read_fIM,
   input  logic         block_read_fIM_valid,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
);

   typedef enum logic [0:0] {
      S_READY = 1'b0,
      S_FILL  = 1'b1
   } state_t;

   state_t               r_state;
   logic [NUM_LINES-1:0] r_valid;
   logic [255:0]         r_data [NUM_LINES];
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   logic [26:0]          r_miss_line;
   logic                 r_blk_read;
   logic [31:0]          r_addr_im;
   logic [31:0]          r_hit_count;
   logic [31:0]          r_miss_count;

   logic [2:0]           w_offset;
   logic [2:0]           w_offset_next;
   logic [INDEX_W-1:0]   w_index;
   logic [TAG_W-1:0]     w_tag;
   logic [255:0]         w_line;
   logic                 w_hit;
   logic                 w_lookup_ok;
   logic                 w_miss;
   logic [INDEX_W-1:0]   w_fill_index;
   logic [TAG_W-1:0]     w_fill_tag;
   logic                 w_install;
   logic                 w_unused;

   assign w_offset      = Instr_address_2IC[4:2];
   assign w_offset_next = w_offset + 3'd1;
   assign w_index       = Instr_address_2IC[INDEX_W+4:5];
   assign w_tag         = Instr_address_2IC[31:INDEX_W+5];
   assign w_line        = r_data[w_index];
   assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_unused      = &{1'b0, Instr_address_2IC[1:0]};

   // A flush cycle is neither a hit nor a miss: IF simply stalls once.
   assign w_lookup_ok   = (r_state == S_READY) && w_hit && !flush;
   assign w_miss        = (r_state == S_READY) && !w_hit && !flush;

   assign w_fill_index  = r_miss_line[INDEX_W-1:0];
   assign w_fill_tag    = r_miss_line[26:INDEX_W];
   assign w_install     = (r_state == S_FILL) && block_read_fIM_valid && !flush;

   always_comb begin
      Instr_valid  = w_lookup_ok;
      Instr1_fIC   = '0;
      Instr2_fIC   = '0;
      Instr2_valid = 1'b0;
      if (w_lookup_ok) begin
         Instr1_fIC = w_line[{w_offset, 5'b0} +: 32];
         if (w_offset != 3'd7) begin
            Instr2_fIC   = w_line[{w_offset_next, 5'b0} +: 32];
            Instr2_valid = 1'b1;
         end
      end
   end

   // Line storage carries no reset; the valid bits alone qualify it.
   always_ff @(posedge CLK) begin
      if (w_install) begin
         r_data[w_fill_index] <= block_read_fIM;
         r_tag[w_fill_index]  <= w_fill_tag;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state      <= S_READY;
         r_valid      <= '0;
         r_miss_line  <= '0;
         r_blk_read   <= 1'b0;
         r_addr_im    <= '0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else begin
         if (w_lookup_ok && (r_hit_count != 32'hFFFF_FFFF))
            r_hit_count <= r_hit_count + 32'd1;
         if (w_miss && (r_miss_count != 32'hFFFF_FFFF))
            r_miss_count <= r_miss_count + 32'd1;

         if (flush) begin
            r_valid    <= '0;
            r_state    <= S_READY;
            r_blk_read <= 1'b0;
            r_addr_im  <= '0;
         end else begin
            case (r_state)
               S_READY: begin
                  if (w_miss) begin
                     r_miss_line <= Instr_address_2IC[31:5];
                     r_addr_im   <= {Instr_address_2IC[31:5], 5'b0};
                     r_blk_read  <= 1'b1;
                     r_state     <= S_FILL;
                  end
               end
               S_FILL: begin
                  if (block_read_fIM_valid) begin
                     r_valid[w_fill_index] <= 1'b1;
                     r_blk_read            <= 1'b0;
                     r_addr_im             <= '0;
                     r_state               <= S_READY;
                  end
               end
               default: r_state <= S_READY;
            endcase
         end
      end
   end

   assign iBlkRead          = r_blk_read;
   assign Instr_address_2IM = r_addr_im;
   assign hit_count         = r_hit_count;
   assign miss_count        = r_miss_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_cache.sv
// +----------------------------------------------------------------------------+
// | tb_instr_cache : directed scoreboard bench for instr_cache                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_instr_cache;

   logic         clk;
   logic         rst;
   logic [31:0]  pc;
   logic [31:0]  instr1;
   logic [31:0]  instr2;
   logic         instr2_valid;
   logic         instr_valid;
   logic         flush;
   logic [31:0]  im_addr;
   logic         blk_read;
   logic [255:0] blk_data;
   logic         blk_valid;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   int checks = 0;
   int errors = 0;
   int exp_hits = 0;
   int exp_misses = 0;

   typedef struct {
      logic [31:0] i1;
      logic [31:0] i2;
      logic        v2;
   } exp_t;

   exp_t sb[$];

   instr_cache dut (
      .CLK                  (clk),
      .RESET                (rst),
      .Instr_address_2IC    (pc),
      .Instr1_fIC           (instr1),
      .Instr2_fIC           (instr2),
      .Instr2_valid         (instr2_valid),
      .Instr_valid          (instr_valid),
      .flush                (flush),
      .Instr_address_2IM    (im_addr),
      .iBlkRead             (blk_read),
      .block_read_fIM       (blk_data),
      .block_read_fIM_valid (blk_valid),
      .hit_count            (hit_count),
      .miss_count           (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ({a[15:0], a[31:16]} ^ 32'h5A3C_96E1) + a;
   endfunction

   function automatic logic [255:0] mem_line(input logic [31:0] base);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word(base + 32'(4 * w));
      return l;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every hit cycle must match the oldest expected fetch, and an
   // expected fetch must not be left pending past its cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (instr_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_hit", 32'(instr_valid), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("instr1", instr1, e.i1);
               chk("instr2", instr2, e.i2);
               chk("instr2_valid", 32'(instr2_valid), 32'(e.v2));
            end
         end else if (sb.size() != 0) begin
            chk("missing_hit", 32'(instr_valid), 32'd1);
            void'(sb.pop_front());
         end
      end
   end

   task automatic expect_hit(input logic [31:0] a);
      exp_t e;
      logic [31:0] base;
      logic [2:0]  off;
      base = {a[31:5], 5'b0};
      off  = a[4:2];
      e.i1 = mem_word(base + {27'd0, off, 2'b0});
      e.v2 = (off != 3'd7);
      e.i2 = e.v2 ? mem_word(base + {27'd0, off, 2'b0} + 32'd4) : 32'd0;
      sb.push_back(e);
      @(negedge clk);
      chk("hit_count", hit_count, 32'(exp_hits));
      chk("hit_no_blkread", 32'(blk_read), 32'd0);
      chk("hit_miss_count", miss_count, 32'(exp_misses));
      exp_hits++;
   endtask

   // Entered one delta after a rising edge with pc already showing a missing address.
   task automatic miss_and_fill(input logic [31:0] a, input int lat,
                                input bit redirect, input bit collide);
      logic [31:0] line;
      bit again;
      line  = {a[31:5], 5'b0};
      again = 1'b1;
      while (again) begin
         again = 1'b0;
         @(negedge clk);
         chk("miss_iv", 32'(instr_valid), 32'd0);
         chk("miss_instr1", instr1, 32'd0);
         chk("miss_count_pre", miss_count, 32'(exp_misses));
         chk("miss_idle_blkread", 32'(blk_read), 32'd0);
         step();
         exp_misses++;
         for (int c = 0; c < lat; c++) begin
            if (redirect) pc = 32'h0050_0040;
            @(negedge clk);
            chk("fill_req", 32'(blk_read), 32'd1);
            chk("fill_addr", im_addr, line);
            chk("fill_miss_count", miss_count, 32'(exp_misses));
            step();
         end
         pc        = a;
         blk_data  = mem_line(line);
         blk_valid = 1'b1;
         if (collide) flush = 1'b1;
         @(negedge clk);
         chk("fill_req_last", 32'(blk_read), 32'd1);
         chk("fill_addr_last", im_addr, line);
         step();
         blk_valid = 1'b0;
         blk_data  = {8{32'hDEAD_0BAD}};
         flush     = 1'b0;
         if (collide) begin
            collide = 1'b0;
            again   = 1'b1;
         end
      end
      expect_hit(a);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      pc        = 32'd0;
      flush     = 1'b0;
      blk_data  = '0;
      blk_valid = 1'b0;
      repeat (2) step();
      chk("rst_blkread", 32'(blk_read), 32'd0);
      chk("rst_im_addr", im_addr, 32'd0);
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
      chk("rst_iv", 32'(instr_valid), 32'd0);
      chk("rst_instr1", instr1, 32'd0);

      // Cold miss, IM answers three cycles after the request
      rst = 1'b0;
      pc  = 32'h0040_0000;
      miss_and_fill(pc, 3, 1'b0, 1'b0);
      chk("cold_miss_count", miss_count, 32'd1);

      // Sequential hits across the line; a stray refill strobe in READY is ignored
      for (int i = 1; i < 8; i++) begin
         step();
         pc        = 32'h0040_0000 + 32'(4 * i);
         blk_valid = (i == 3);
         blk_data  = ~mem_line(32'h0040_0000);
         expect_hit(pc);
      end
      blk_valid = 1'b0;

      // Conflict on index 0, with a PC redirect during one fill
      step(); pc = 32'h0040_0000; expect_hit(pc);
      step(); pc = 32'h0040_0800; miss_and_fill(pc, 1, 1'b1, 1'b0);
      step(); pc = 32'h0040_0000; miss_and_fill(pc, 2, 1'b0, 1'b0);
      chk("conflict_misses", miss_count, 32'd3);

      // Flush on a hitting address
      step(); pc = 32'h0040_0000; expect_hit(pc);
      step(); flush = 1'b1;
      @(negedge clk);
      chk("flush_iv", 32'(instr_valid), 32'd0);
      chk("flush_iv2", 32'(instr2_valid), 32'd0);
      chk("flush_miss_count", miss_count, 32'(exp_misses));
      step(); flush = 1'b0;
      miss_and_fill(pc, 1, 1'b0, 1'b0);

      // Flush colliding with refill data: line dropped, fetch misses again
      step(); pc = 32'h0040_1040; miss_and_fill(pc, 2, 1'b0, 1'b1);
      step(); pc = 32'h0040_105C; expect_hit(pc);

      // Asynchronous reset in the middle of a fill
      step(); pc = 32'h0040_2000;
      @(negedge clk);
      chk("r6_miss_iv", 32'(instr_valid), 32'd0);
      step();
      chk("r6_fill_req", 32'(blk_read), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("r6_blkread", 32'(blk_read), 32'd0);
      chk("r6_im_addr", im_addr, 32'd0);
      chk("r6_hit_count", hit_count, 32'd0);
      chk("r6_miss_count", miss_count, 32'd0);
      exp_hits   = 0;
      exp_misses = 0;
      step();
      rst = 1'b0;
      pc  = 32'h0040_1040;
      miss_and_fill(pc, 1, 1'b0, 1'b0);

      step();
      pc = 32'h0040_0000;
      @(negedge clk);
      chk("end_queue_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
